// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry constants, controller state enum and address-split helpers.
//   DEF_*       default cache geometry shared with the tag array
//   state_t     controller FSM states
//   addr_tag / addr_index / addr_offset   split a byte address at default geometry
package cache_pkg;
  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_LINE_SIZE     = 64;
  localparam int DEF_NUM_SETS      = 64;
  localparam int DEF_ASSOCIATIVITY = 4;
  localparam int DEF_OFFSET_WIDTH  = $clog2(DEF_LINE_SIZE);
  localparam int DEF_INDEX_WIDTH   = $clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_WIDTH     = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;
  localparam int DEF_WAY_WIDTH     = $clog2(DEF_ASSOCIATIVITY);
  typedef enum logic [3:0] {
    IDLE, LOOKUP, CHECK, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, TAG_UPD, RESP
  } state_t;
  function automatic logic [DEF_TAG_WIDTH-1:0] addr_tag(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_ADDR_WIDTH-1 -: DEF_TAG_WIDTH];
  endfunction
  function automatic logic [DEF_INDEX_WIDTH-1:0] addr_index(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_OFFSET_WIDTH +: DEF_INDEX_WIDTH];
  endfunction
  function automatic logic [DEF_OFFSET_WIDTH-1:0] addr_offset(input logic [DEF_ADDR_WIDTH-1:0] a);
    return a[DEF_OFFSET_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/cache_rr_victim.sv
// cache_rr_victim: per-set round-robin victim way pointers.
//   clk, rst_n  clock, asynchronous active-low reset (all pointers to 0)
//   index       set whose pointer is read and advanced
//   advance     step the pointer of index, wrapping at ASSOCIATIVITY
//   way_out     current victim way of index
module cache_rr_victim
  import cache_pkg::*;
#(
  parameter int NUM_SETS      = DEF_NUM_SETS,
  parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
  parameter int INDEX_WIDTH   = $clog2(NUM_SETS),
  parameter int WAY_WIDTH     = $clog2(ASSOCIATIVITY)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   advance,
  output logic [WAY_WIDTH-1:0]   way_out
);
  logic [WAY_WIDTH-1:0] ptr [NUM_SETS];
  assign way_out = ptr[index];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_SETS; i++) ptr[i] <= '0;
    else if (advance)
      ptr[index] <= (ptr[index] == WAY_WIDTH'(ASSOCIATIVITY - 1)) ? '0 : ptr[index] + 1'b1;
endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: request-side cache controller sequencing lookup, writeback, refill and tag update.
//   cpu_req_*  / cpu_resp_*   one-at-a-time CPU request and one-cycle completion pulse
//   tag_*                     tag array lookup (result one cycle after tag_rd_en) and write ports
//   mem_req_* / mem_resp_valid  line writeback/refill over valid/ready, completion pulse
//   perf_*                    hit/miss/writeback counters, saturating
// Optional feature macro: CACHE_PERF_CNT_EN (undefined: perf_* tied to 0, no counter flops).
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int NUM_SETS      = DEF_NUM_SETS,
  parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
  parameter int OFFSET_WIDTH  = $clog2(LINE_SIZE),
  parameter int INDEX_WIDTH   = $clog2(NUM_SETS),
  parameter int TAG_WIDTH     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int WAY_WIDTH     = $clog2(ASSOCIATIVITY)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
  input  logic                   cpu_req_we,
  output logic                   cpu_resp_valid,
  output logic                   cpu_resp_hit,
  output logic [WAY_WIDTH-1:0]   cpu_resp_way,
  output logic                   tag_rd_en,
  output logic                   tag_wr_en,
  output logic [INDEX_WIDTH-1:0] tag_index,
  output logic [TAG_WIDTH-1:0]   tag_tag,
  output logic [WAY_WIDTH-1:0]   tag_way,
  output logic                   tag_wr_dirty,
  input  logic                   tag_hit,
  input  logic [WAY_WIDTH-1:0]   tag_hit_way,
  input  logic                   tag_dirty,
  input  logic [TAG_WIDTH-1:0]   tag_victim_tag,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  output logic [31:0]            perf_hit_cnt,
  output logic [31:0]            perf_miss_cnt,
  output logic [31:0]            perf_wb_cnt
);
  state_t state;
  logic req_we;
  logic [WAY_WIDTH-1:0] rr_way;
  logic [INDEX_WIDTH-1:0] in_index, rr_index;
  logic fill_done;
  logic unused_offset;
  assign in_index      = cpu_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_offset = ^cpu_req_addr[OFFSET_WIDTH-1:0];
  // In IDLE the pointer is read for the incoming request so tag_way is valid in LOOKUP.
  assign rr_index  = state == IDLE ? in_index : tag_index;
  assign fill_done = state == FILL_WAIT && mem_resp_valid;
  cache_rr_victim #(
    .NUM_SETS(NUM_SETS), .ASSOCIATIVITY(ASSOCIATIVITY),
    .INDEX_WIDTH(INDEX_WIDTH), .WAY_WIDTH(WAY_WIDTH)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .index(rr_index), .advance(fill_done), .way_out(rr_way)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      req_we         <= 1'b0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_hit   <= 1'b0;
      cpu_resp_way   <= '0;
      tag_rd_en      <= 1'b0;
      tag_wr_en      <= 1'b0;
      tag_index      <= '0;
      tag_tag        <= '0;
      tag_way        <= '0;
      tag_wr_dirty   <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
    end else
      case (state)
        IDLE:
          if (cpu_req_valid && cpu_req_ready) begin
            state         <= LOOKUP;
            cpu_req_ready <= 1'b0;
            req_we        <= cpu_req_we;
            tag_rd_en     <= 1'b1;
            tag_index     <= in_index;
            tag_tag       <= cpu_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            tag_way       <= rr_way;
          end
        LOOKUP: begin
          tag_rd_en <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          cpu_resp_hit <= tag_hit;
          cpu_resp_way <= tag_hit ? tag_hit_way : tag_way;
          if (tag_hit && req_we) begin
            state        <= TAG_UPD;
            tag_wr_en    <= 1'b1;
            tag_way      <= tag_hit_way;
            tag_wr_dirty <= 1'b1;
          end else if (tag_hit) begin
            state          <= RESP;
            cpu_resp_valid <= 1'b1;
          end else begin
            state         <= tag_dirty ? WB_REQ : FILL_REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= tag_dirty;
            mem_req_addr  <= {(tag_dirty ? tag_victim_tag : tag_tag), tag_index, {OFFSET_WIDTH{1'b0}}};
          end
        end
        WB_REQ, FILL_REQ:
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= state == WB_REQ ? WB_WAIT : FILL_WAIT;
          end
        WB_WAIT:
          if (mem_resp_valid) begin
            state         <= FILL_REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {tag_tag, tag_index, {OFFSET_WIDTH{1'b0}}};
          end
        FILL_WAIT:
          if (mem_resp_valid) begin
            state        <= TAG_UPD;
            tag_wr_en    <= 1'b1;
            tag_wr_dirty <= req_we;
          end
        TAG_UPD: begin
          tag_wr_en      <= 1'b0;
          state          <= RESP;
          cpu_resp_valid <= 1'b1;
        end
        RESP: begin
          cpu_resp_valid <= 1'b0;
          cpu_req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (state == CHECK && tag_hit && !(&perf_hit_cnt)) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (state == CHECK && !tag_hit && !(&perf_miss_cnt)) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (state == WB_REQ && mem_req_ready && !(&perf_wb_cnt)) perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
  assign perf_wb_cnt   = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: self-checking bench with tag-array and memory emulation plus a cache reference model.
module tb_cache_ctrl_fsm;
  import cache_pkg::*;
  localparam int NS = 64, NW = 4, IW = 6, TW = 20, WW = 2;
`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req_valid = 1'b0, cpu_req_we = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic cpu_req_ready, cpu_resp_valid, cpu_resp_hit;
  logic [WW-1:0] cpu_resp_way;
  logic tag_rd_en, tag_wr_en, tag_wr_dirty;
  logic [IW-1:0] tag_index;
  logic [TW-1:0] tag_tag;
  logic [WW-1:0] tag_way;
  logic tag_hit = 1'b0, tag_dirty = 1'b0;
  logic [WW-1:0] tag_hit_way = '0;
  logic [TW-1:0] tag_victim_tag = '0;
  logic mem_req_valid, mem_req_we;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;

  always #5 clk = ~clk;

  cache_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit), .cpu_resp_way(cpu_resp_way),
    .tag_rd_en(tag_rd_en), .tag_wr_en(tag_wr_en), .tag_index(tag_index), .tag_tag(tag_tag),
    .tag_way(tag_way), .tag_wr_dirty(tag_wr_dirty), .tag_hit(tag_hit), .tag_hit_way(tag_hit_way),
    .tag_dirty(tag_dirty), .tag_victim_tag(tag_victim_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
  );

  int errors = 0, checks = 0, cyc = 0;
  bit ev [NS][NW];
  bit ed [NS][NW];
  logic [TW-1:0] et [NS][NW];
  bit mv [NS][NW];
  bit md [NS][NW];
  logic [TW-1:0] mt [NS][NW];
  int mrr [NS];
  int m_hits = 0, m_miss = 0, m_wbs = 0;
  bit e_hit, e_wb, e_wr, e_wr_dirty;
  int e_way;
  logic [31:0] e_wb_addr, e_fill_addr;
  bit rd_pend = 0;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] rd_tag;
  logic [WW-1:0] rd_way;
  int rdy_dly = 0, rsp_dly = 0, rsp_cd = 0, mq_wait = 0, n_mv, n_rd, n_wr, both;
  bit mv_hold = 0, mv_we;
  logic [31:0] mv_addr;
  logic [31:0] mq_addr [$];
  bit mq_we [$];
  int last_mresp, resp_c, resp_way, wr_way;
  bit resp_seen, resp_hit, wr_dirty;
  logic [TW-1:0] wr_tag;
  bit chk_stable = 0;
  logic [IW-1:0] s_idx;
  logic [TW-1:0] s_tag;

  function automatic void predict(input logic [31:0] a, input bit we);
    int idx = int'(addr_index(a));
    logic [TW-1:0] t = addr_tag(a);
    e_hit = 0; e_way = 0; e_wb = 0; e_wr = 0; e_wr_dirty = 0;
    for (int w = 0; w < NW; w++) if (mv[idx][w] && mt[idx][w] == t) begin e_hit = 1; e_way = w; end
    e_fill_addr = {t, IW'(idx), 6'd0};
    if (e_hit) begin
      m_hits++;
      e_wr = we; e_wr_dirty = 1;
      if (we) md[idx][e_way] = 1;
    end else begin
      m_miss++;
      e_way = mrr[idx];
      e_wb = mv[idx][e_way] && md[idx][e_way];
      if (e_wb) m_wbs++;
      e_wb_addr = {mt[idx][e_way], IW'(idx), 6'd0};
      e_wr = 1; e_wr_dirty = we;
      mv[idx][e_way] = 1; mt[idx][e_way] = t; md[idx][e_way] = we;
      mrr[idx] = (mrr[idx] + 1) % NW;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1; cyc++;
    if (rd_pend) begin
      tag_hit = 0; tag_hit_way = WW'($urandom);
      for (int w = 0; w < NW; w++) if (ev[rd_idx][w] && et[rd_idx][w] == rd_tag) begin tag_hit = 1; tag_hit_way = WW'(w); end
      tag_dirty = tag_hit ? ed[rd_idx][tag_hit_way] : ed[rd_idx][rd_way];
      tag_victim_tag = et[rd_idx][rd_way];
    end else begin
      tag_hit = 1'($urandom); tag_hit_way = WW'($urandom); tag_dirty = 1'($urandom); tag_victim_tag = TW'($urandom);
    end
    rd_pend = 0;
    if (tag_rd_en) begin rd_pend = 1; rd_idx = tag_index; rd_tag = tag_tag; rd_way = tag_way; n_rd++; end
    if (tag_wr_en) begin
      n_wr++; wr_way = tag_way; wr_dirty = tag_wr_dirty; wr_tag = tag_tag;
      ev[tag_index][tag_way] = 1; et[tag_index][tag_way] = tag_tag; ed[tag_index][tag_way] = tag_wr_dirty;
    end
    if (tag_rd_en && tag_wr_en) both++;
    if (chk_stable) begin
      checks++;
      if (tag_index !== s_idx || tag_tag !== s_tag) begin
        errors++; $display("FAIL tag_stable: index=%h tag=%h, expected index=%h tag=%h", tag_index, tag_tag, s_idx, s_tag);
      end
    end
    mem_resp_valid = 0;
    if (rsp_cd > 0) begin rsp_cd--; if (rsp_cd == 0) begin mem_resp_valid = 1; last_mresp = cyc; end end
    mem_req_ready = 0;
    if (mem_req_valid) begin
      n_mv++;
      checks++;
      if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL ready_busy: cpu_req_ready=%b, expected 0", cpu_req_ready); end
      if (mv_hold) begin
        checks++;
        if (mem_req_addr !== mv_addr || mem_req_we !== mv_we) begin
          errors++; $display("FAIL mem_stable: addr=%h we=%b, expected addr=%h we=%b", mem_req_addr, mem_req_we, mv_addr, mv_we);
        end
      end
      mv_addr = mem_req_addr; mv_we = mem_req_we;
      if (mq_wait >= rdy_dly) begin
        mem_req_ready = 1; mq_addr.push_back(mem_req_addr); mq_we.push_back(mem_req_we);
        rsp_cd = rsp_dly + 1; mq_wait = 0; mv_hold = 0;
      end else begin
        mq_wait++; mv_hold = 1;
      end
    end
    if (cpu_resp_valid) begin resp_seen = 1; resp_c = cyc; resp_hit = cpu_resp_hit; resp_way = int'(cpu_resp_way); chk_stable = 0; end
  endtask

  task automatic run_req(input logic [31:0] a, input bit we, input int rd, input int sd, output int hs);
    rdy_dly = rd; rsp_dly = sd;
    mq_addr.delete(); mq_we.delete();
    n_rd = 0; n_wr = 0; n_mv = 0; both = 0; resp_seen = 0; last_mresp = -100;
    cpu_req_valid = 1; cpu_req_addr = a; cpu_req_we = we; hs = cyc;
    s_idx = addr_index(a); s_tag = addr_tag(a); chk_stable = 1;
    step();
    cpu_req_valid = 0; cpu_req_addr = $urandom; cpu_req_we = 1'($urandom);
    for (int g = 0; g < 200 && !resp_seen; g++) step();
    chk_stable = 0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_req_ready, cpu_resp_valid, tag_rd_en, tag_wr_en, mem_req_valid} !== 5'b10000 ||
        mem_req_addr !== 32'd0 || tag_index !== '0 || cpu_resp_hit !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: rdy,rv,rd,wr,mv=%b addr=%h, expected 10000 addr=0",
        {cpu_req_ready, cpu_resp_valid, tag_rd_en, tag_wr_en, mem_req_valid}, mem_req_addr);
    end
    checks++;
    if ({perf_hit_cnt, perf_miss_cnt, perf_wb_cnt} !== 96'd0) begin
      errors++; $display("FAIL reset_perf: %0d %0d %0d, expected 0 0 0", perf_hit_cnt, perf_miss_cnt, perf_wb_cnt);
    end
    rst_n = 1;
    step();
    checks++;
    if (cpu_req_ready !== 1'b1 || tag_rd_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: ready=%b rd_en=%b, expected 1 0", cpu_req_ready, tag_rd_en);
    end
  endtask

  task automatic test_clean_miss();
    int hs;
    predict(32'h0000_1040, 0);
    run_req(32'h0000_1040, 0, 0, 0, hs);
    checks++;
    if (!resp_seen || resp_hit !== 1'b0 || resp_way != 0) begin
      errors++; $display("FAIL miss_resp: seen=%b hit=%b way=%0d, expected 1 0 0", resp_seen, resp_hit, resp_way);
    end
    checks++;
    if (mq_addr.size() != 1 || mq_addr[0] !== 32'h0000_1040 || mq_we[0] !== 1'b0) begin
      errors++; $display("FAIL miss_mem: n=%0d addr=%h, expected 1 refill at 00001040", mq_addr.size(), mv_addr);
    end
    checks++;
    if (n_wr != 1 || wr_way != 0 || wr_dirty !== 1'b0 || both != 0 || n_rd != 1) begin
      errors++; $display("FAIL miss_tag: writes=%0d way=%0d dirty=%b reads=%0d overlap=%0d, expected 1 0 0 1 0", n_wr, wr_way, wr_dirty, n_rd, both);
    end
    checks++;
    if (resp_c != last_mresp + 2) begin
      errors++; $display("FAIL miss_latency: resp at %0d, expected %0d", resp_c, last_mresp + 2);
    end
  endtask

  task automatic test_read_hit();
    int hs;
    predict(32'h0000_1040, 0);
    run_req(32'h0000_1040, 0, 0, 0, hs);
    checks++;
    if (!resp_seen || resp_hit !== 1'b1 || resp_way != 0 || resp_c - hs != 3) begin
      errors++; $display("FAIL read_hit: seen=%b hit=%b way=%0d lat=%0d, expected 1 1 0 3", resp_seen, resp_hit, resp_way, resp_c - hs);
    end
    checks++;
    if (mq_addr.size() != 0 || n_wr != 0) begin
      errors++; $display("FAIL read_hit_side: mem=%0d writes=%0d, expected 0 0", mq_addr.size(), n_wr);
    end
  endtask

  task automatic test_write_hit();
    int hs;
    predict(32'h0000_1040, 1);
    run_req(32'h0000_1040, 1, 0, 0, hs);
    checks++;
    if (!resp_seen || resp_hit !== 1'b1 || resp_way != 0 || resp_c - hs != 4) begin
      errors++; $display("FAIL write_hit: seen=%b hit=%b way=%0d lat=%0d, expected 1 1 0 4", resp_seen, resp_hit, resp_way, resp_c - hs);
    end
    checks++;
    if (mq_addr.size() != 0 || n_wr != 1 || wr_way != 0 || wr_dirty !== 1'b1) begin
      errors++; $display("FAIL write_hit_tag: mem=%0d writes=%0d way=%0d dirty=%b, expected 0 1 0 1", mq_addr.size(), n_wr, wr_way, wr_dirty);
    end
  endtask

  task automatic test_writeback();
    int hs;
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] a;
      a = 32'h0000_0040 | (i + 1) << 12;
      predict(a, 0);
      run_req(a, 0, 0, i, hs);
      checks++;
      if (!resp_seen || resp_hit !== 1'b0 || resp_way != i) begin
        errors++; $display("FAIL fill_way%0d: seen=%b hit=%b way=%0d, expected 1 0 %0d", i, resp_seen, resp_hit, resp_way, i);
      end
    end
    predict(32'h0000_5040, 0);
    run_req(32'h0000_5040, 0, 1, 2, hs);
    checks++;
    if (mq_addr.size() != 2 || mq_addr[0] !== 32'h0000_1040 || mq_we[0] !== 1'b1 ||
        mq_addr[1] !== 32'h0000_5040 || mq_we[1] !== 1'b0) begin
      errors++; $display("FAIL wb_seq: n=%0d, expected writeback 00001040 then refill 00005040", mq_addr.size());
    end
    checks++;
    if (!resp_seen || resp_hit !== 1'b0 || resp_way != 0 || n_wr != 1 || wr_way != 0 || wr_dirty !== 1'b0) begin
      errors++; $display("FAIL wb_resp: hit=%b way=%0d writes=%0d wway=%0d dirty=%b, expected 0 0 1 0 0", resp_hit, resp_way, n_wr, wr_way, wr_dirty);
    end
    checks++;
    if (perf_wb_cnt !== 32'(PERF ? 1 : 0)) begin
      errors++; $display("FAIL perf_wb: %0d, expected %0d", perf_wb_cnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_stall();
    int hs;
    predict(32'h0000_6080, 0);
    run_req(32'h0000_6080, 0, 5, 2, hs);
    checks++;
    if (n_mv != 6 || mq_addr.size() != 1 || mq_addr[0] !== 32'h0000_6080) begin
      errors++; $display("FAIL stall_req: valid_cycles=%0d n=%0d, expected 6 1", n_mv, mq_addr.size());
    end
    checks++;
    if (!resp_seen || resp_c != last_mresp + 2 || resp_hit !== 1'b0) begin
      errors++; $display("FAIL stall_resp: seen=%b at %0d, expected miss at %0d", resp_seen, resp_c, last_mresp + 2);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    rdy_dly = 0; rsp_dly = 1000; mq_addr.delete(); mq_we.delete(); resp_seen = 0;
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_7240; cpu_req_we = 0;
    step();
    cpu_req_valid = 0;
    for (int g = 0; g < 20 && mq_addr.size() == 0; g++) step();
    step(); step();
    checks++;
    if (mq_addr.size() != 1 || resp_seen) begin
      errors++; $display("FAIL mid_setup: n=%0d resp=%b, expected 1 0", mq_addr.size(), resp_seen);
    end
    rst_n = 0; #1;
    rsp_cd = 0; rd_pend = 0; mv_hold = 0; mq_wait = 0;
    checks++;
    if ({cpu_req_ready, cpu_resp_valid, tag_rd_en, tag_wr_en, mem_req_valid} !== 5'b10000 ||
        {perf_hit_cnt, perf_miss_cnt, perf_wb_cnt} !== 96'd0) begin
      errors++; $display("FAIL mid_reset: rdy,rv,rd,wr,mv=%b, expected 10000 with zero counters",
        {cpu_req_ready, cpu_resp_valid, tag_rd_en, tag_wr_en, mem_req_valid});
    end
    step();
    #2 rst_n = 1;
    step();
    checks++;
    if (resp_seen || cpu_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_abort: resp=%b ready=%b, expected 0 1", resp_seen, cpu_req_ready);
    end
    for (int s = 0; s < NS; s++) mrr[s] = 0;
    m_hits = 0; m_miss = 0; m_wbs = 0;
    predict(32'h0000_7240, 0);
    run_req(32'h0000_7240, 0, 0, 1, hs);
    checks++;
    if (!resp_seen || resp_hit !== 1'b0 || resp_way != 0 || mq_addr.size() != 1 || mq_addr[0] !== 32'h0000_7240) begin
      errors++; $display("FAIL mid_recover: seen=%b hit=%b way=%0d n=%0d, expected 1 0 0 1", resp_seen, resp_hit, resp_way, mq_addr.size());
    end
  endtask

  task automatic test_random();
    int hs, nexp;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      bit we;
      a = {20'($urandom_range(5, 0)), 6'(4 + $urandom_range(1, 0)), 6'($urandom)};
      we = 1'($urandom);
      checks++;
      if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: %b, expected 1", i, cpu_req_ready); end
      predict(a, we);
      run_req(a, we, $urandom_range(2, 0), $urandom_range(3, 0), hs);
      checks++;
      if (!resp_seen || resp_hit !== e_hit || resp_way != e_way) begin
        errors++; $display("FAIL rnd_resp[%0d] addr=%h: seen=%b hit=%b way=%0d, expected 1 %b %0d", i, a, resp_seen, resp_hit, resp_way, e_hit, e_way);
      end
      nexp = e_hit ? 0 : (e_wb ? 2 : 1);
      checks++;
      if (mq_addr.size() != nexp || (e_wb && (mq_addr[0] !== e_wb_addr || mq_we[0] !== 1'b1)) ||
          (!e_hit && (mq_addr[nexp-1] !== e_fill_addr || mq_we[nexp-1] !== 1'b0))) begin
        errors++; $display("FAIL rnd_mem[%0d] addr=%h: n=%0d, expected %0d wb=%h fill=%h", i, a, mq_addr.size(), nexp, e_wb_addr, e_fill_addr);
      end
      checks++;
      if (n_wr != int'(e_wr) || (e_wr && (wr_way != e_way || wr_dirty !== e_wr_dirty || wr_tag !== addr_tag(a))) || both != 0 || n_rd != 1) begin
        errors++; $display("FAIL rnd_tag[%0d]: writes=%0d way=%0d dirty=%b reads=%0d, expected %0d %0d %b 1", i, n_wr, wr_way, wr_dirty, n_rd, e_wr, e_way, e_wr_dirty);
      end
      checks++;
      if (resp_c != (e_hit ? hs + (we ? 4 : 3) : last_mresp + 2)) begin
        errors++; $display("FAIL rnd_latency[%0d]: resp at %0d, expected %0d", i, resp_c, e_hit ? hs + (we ? 4 : 3) : last_mresp + 2);
      end
    end
    checks++;
    if (perf_hit_cnt !== 32'(PERF ? m_hits : 0) || perf_miss_cnt !== 32'(PERF ? m_miss : 0) || perf_wb_cnt !== 32'(PERF ? m_wbs : 0)) begin
      errors++; $display("FAIL rnd_perf: %0d %0d %0d, expected %0d %0d %0d", perf_hit_cnt, perf_miss_cnt, perf_wb_cnt,
        PERF ? m_hits : 0, PERF ? m_miss : 0, PERF ? m_wbs : 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_writeback();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Request-side controller that sits directly upstream of the tag array. It accepts one CPU request at a time and drives the tag array's lookup and write ports. It decides hit or miss, picks the victim way, and sequences a line writeback (if the victim is dirty), a line refill and the tag update over a valid/ready memory interface before responding to the CPU. It handles line-granular control only; data movement belongs to the data-array path.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_SIZE, 64, bytes per line
NUM_SETS, 64, sets
ASSOCIATIVITY, 4, ways per set
OFFSET_WIDTH, $clog2(LINE_SIZE), offset bits
INDEX_WIDTH, $clog2(NUM_SETS), index bits
TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, tag bits
WAY_WIDTH, $clog2(ASSOCIATIVITY), way select bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept
cpu_req_addr  in  ADDR_WIDTH  request byte address
cpu_req_we  in  1  1=write, 0=read
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_hit  out  1  request hit in cache
cpu_resp_way  out  WAY_WIDTH  way holding the line
tag_rd_en  out  1  tag lookup strobe
tag_wr_en  out  1  tag write strobe
tag_index  out  INDEX_WIDTH  set index to tag array
tag_tag  out  TAG_WIDTH  tag to compare/write
tag_way  out  WAY_WIDTH  victim/write way
tag_wr_dirty  out  1  written entry state: 1=DIRTY, 0=VALID
tag_hit  in  1  lookup hit, valid cycle after tag_rd_en
tag_hit_way  in  WAY_WIDTH  hitting way
tag_dirty  in  1  hit way dirty (hit) / tag_way dirty (miss)
tag_victim_tag  in  TAG_WIDTH  stored tag of tag_way
mem_req_valid  out  1  line transfer request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=writeback, 0=refill
mem_req_addr  out  ADDR_WIDTH  line-aligned address
mem_resp_valid  in  1  transfer complete pulse
perf_hit_cnt  out  32  hit count
perf_miss_cnt  out  32  miss count
perf_wb_cnt  out  32  writeback count

Behaviour:
- States: IDLE, LOOKUP, CHECK, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, TAG_UPD, RESP.
- Reset (async): state=IDLE; all outputs 0 except cpu_req_ready=1; round-robin pointers 0; latched request cleared.
- IDLE: cpu_req_ready=1. Handshake (valid&ready) latches addr and we, then goes to LOOKUP. No other state asserts ready.
- LOOKUP (1 cycle): tag_rd_en=1; tag_index/tag_tag from latched address; tag_way=rr_ptr[index]. Next state CHECK.
- CHECK: samples tag_hit, tag_hit_way, tag_dirty and tag_victim_tag.
  - Read hit -> RESP.
  - Write hit -> TAG_UPD (way=hit_way, dirty=1).
  - Miss with tag_dirty=1 -> WB_REQ.
  - Clean miss -> FILL_REQ.
- WB_REQ: mem_req_valid=1, we=1, addr={victim_tag,index,0}. Request is held stable until mem_req_ready, then WB_WAIT.
- FILL_REQ: mem_req_valid=1, we=0, addr={req_tag,index,0}. Request is held stable until mem_req_ready, then FILL_WAIT.
- WB_WAIT: mem_resp_valid -> FILL_REQ.
- FILL_WAIT: mem_resp_valid -> TAG_UPD with way=victim and dirty=req_we; victim pointer increments mod ASSOCIATIVITY.
- mem_resp_valid is ignored in all other states.
- TAG_UPD (1 cycle): tag_wr_en=1. Next state RESP.
- RESP (1 cycle): cpu_resp_valid=1, hit/way reported. Next state IDLE.
- Latency from handshake cycle N:
  - Read hit: resp at N+3.
  - Write hit: resp at N+4.
  - Clean miss, ready immediate: resp at M+2, where M is the mem_resp_valid cycle.
- tag_rd_en and tag_wr_en are never asserted together. tag_index and tag_tag stay stable from LOOKUP until RESP.
- Reset mid-transaction: abort immediately; no response; mem_req_valid drops.

Optional Feature:
CACHE_PERF_CNT_EN
- Defined: three 32-bit counters.
  - hits increment in CHECK on hit.
  - misses increment in CHECK on miss.
  - writebacks increment at the WB_REQ handshake.
  - All counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: perf_* ports are present and tied to 0; no counter flops.

Decomposition:
- Package cache_pkg holds:
  - the state enum;
  - address-split helper functions (tag/index/offset);
  - default geometry constants shared with the tag array.
- One natural sub-module: cache_rr_victim, a per-set WAY_WIDTH round-robin pointer array with ports index, advance, way_out.

Test Plan:
- Reset, then read 0x0000_1040 (index 1, tag 1) with empty cache -> clean miss; mem req we=0 addr 0x0000_1040; after resp, tag_wr_en way 0 dirty=0; cpu_resp_hit=0, way 0.
- Repeat the read of 0x0000_1040 -> tag_hit=1 way 0; cpu_resp_valid exactly 3 cycles after handshake; hit=1; no mem request.
- Write 0x0000_1040 on hit -> TAG_UPD way 0 dirty=1; resp at N+4; no mem request.
- Fill ways 1-3 of set 1, then miss on 0x0000_5040 with victim way 0 dirty (tag 1) -> writeback addr 0x0000_1040 we=1, then refill 0x0000_5040, tag write way 0; perf_wb_cnt=1 when CACHE_PERF_CNT_EN is defined.
- mem_req_ready held low 5 cycles during FILL_REQ -> mem_req_valid and addr stable throughout; cpu_req_ready=0.
- Assert rst_n low during FILL_WAIT -> next cycle all outputs at reset values; a new request afterwards completes normally.
